// File: rtl/tof_interval_counter.sv
// Time-of-flight interval counter: after arm, timestamps stop edges relative to the first
// start edge, ending on NUM_STOPS captures or a programmable timeout. Avalon-MM register slave.
module tof_interval_counter #(
   parameter int NUM_STOPS   = 5,
   parameter int CNT_W       = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic        avmm_clk,
   input  logic        avmm_reset,
   input  logic        avmm_cs,
   input  logic [2:0]  avmm_addr,
   input  logic        avmm_write,
   input  logic [31:0] avmm_writedata,
   input  logic        avmm_read,
   output logic [31:0] avmm_readdata,
   input  logic        start_in,
   input  logic        stop_in,
   output logic        irq
);
   typedef enum logic [1:0] {IDLE, ARMED, MEASURE, DONE} state_t;
   localparam logic [2:0] LAST_STOP = 3'(NUM_STOPS - 1);

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       counter_reg, counter_next, counter_inc;
   logic [CNT_W-1:0]       timeout_reg;
   logic [CNT_W-1:0]       stop_ts_reg [NUM_STOPS];
   logic [2:0]             stop_cnt_reg, stop_cnt_next;
   logic                   done_reg, done_next;
   logic                   tmo_flag_reg, tmo_flag_next;
   logic                   irq_en_reg, irq_reg;
   logic                   capture, wipe, busy;
   logic [SYNC_STAGES-1:0] start_sync_reg, stop_sync_reg;
   logic                   start_prev_reg, stop_prev_reg;
   logic                   start_ev, stop_ev;
   logic                   ctrl_wr, arm_cmd, clear_cmd, tmo_wr, rd_en;
   logic [31:0]            rd_mux;

   // Both inputs see the same synchronizer depth, so intervals stay exact in cycles
   always_ff @(posedge avmm_clk or posedge avmm_reset) begin
      if (avmm_reset) begin
         start_sync_reg <= '0;
         stop_sync_reg  <= '0;
         start_prev_reg <= 1'b0;
         stop_prev_reg  <= 1'b0;
      end else begin
         start_sync_reg <= {start_sync_reg[SYNC_STAGES-2:0], start_in};
         stop_sync_reg  <= {stop_sync_reg[SYNC_STAGES-2:0], stop_in};
         start_prev_reg <= start_sync_reg[SYNC_STAGES-1];
         stop_prev_reg  <= stop_sync_reg[SYNC_STAGES-1];
      end
   end

   assign start_ev  = start_sync_reg[SYNC_STAGES-1] & ~start_prev_reg;
   assign stop_ev   = stop_sync_reg[SYNC_STAGES-1] & ~stop_prev_reg;

   assign ctrl_wr   = avmm_cs & avmm_write & (avmm_addr == 3'd0);
   assign tmo_wr    = avmm_cs & avmm_write & (avmm_addr == 3'd1);
   assign rd_en     = avmm_cs & avmm_read;
   assign clear_cmd = ctrl_wr & avmm_writedata[1];
   assign arm_cmd   = ctrl_wr & avmm_writedata[0] & ~avmm_writedata[1];

   assign counter_inc = (&counter_reg) ? counter_reg : counter_reg + CNT_W'(1);
   assign busy        = (state_reg == ARMED) || (state_reg == MEASURE);

   always_comb begin
      state_next    = state_reg;
      counter_next  = counter_reg;
      stop_cnt_next = stop_cnt_reg;
      done_next     = done_reg;
      tmo_flag_next = tmo_flag_reg;
      capture       = 1'b0;
      wipe          = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (arm_cmd) begin
               wipe          = 1'b1;
               stop_cnt_next = 3'd0;
               done_next     = 1'b0;
               tmo_flag_next = 1'b0;
               state_next    = ARMED;
            end
         end
         ARMED: begin
            if (start_ev) begin
               counter_next = '0;
               state_next   = MEASURE;
            end
         end
         MEASURE: begin
            counter_next = counter_inc;
            if (stop_ev) begin
               capture       = 1'b1;
               stop_cnt_next = stop_cnt_reg + 3'd1;
            end
            // A stop landing on the timeout cycle is captured; it only avoids the
            // timeout flag when it is the terminal stop.
            if (stop_ev && (stop_cnt_reg == LAST_STOP)) begin
               done_next  = 1'b1;
               state_next = DONE;
            end else if ((timeout_reg != '0) && (counter_inc == timeout_reg)) begin
               done_next     = 1'b1;
               tmo_flag_next = 1'b1;
               state_next    = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (clear_cmd) begin
         wipe          = 1'b1;
         stop_cnt_next = 3'd0;
         done_next     = 1'b0;
         tmo_flag_next = 1'b0;
         state_next    = IDLE;
      end
   end

   always_ff @(posedge avmm_clk or posedge avmm_reset) begin
      if (avmm_reset) begin
         state_reg    <= IDLE;
         counter_reg  <= '0;
         stop_cnt_reg <= 3'd0;
         done_reg     <= 1'b0;
         tmo_flag_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         counter_reg  <= counter_next;
         stop_cnt_reg <= stop_cnt_next;
         done_reg     <= done_next;
         tmo_flag_reg <= tmo_flag_next;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_STOPS; gi++) begin : g_ts
         always_ff @(posedge avmm_clk or posedge avmm_reset) begin
            if (avmm_reset)
               stop_ts_reg[gi] <= '0;
            else if (wipe)
               stop_ts_reg[gi] <= '0;
            else if (capture && (stop_cnt_reg == 3'(gi)))
               stop_ts_reg[gi] <= counter_inc;
         end
      end
   endgenerate

   always_ff @(posedge avmm_clk or posedge avmm_reset) begin
      if (avmm_reset) begin
         timeout_reg <= '0;
         irq_en_reg  <= 1'b0;
         irq_reg     <= 1'b0;
      end else begin
         if (tmo_wr)
            timeout_reg <= avmm_writedata[CNT_W-1:0];
         if (ctrl_wr)
            irq_en_reg <= avmm_writedata[2];
         irq_reg <= done_reg & irq_en_reg;
      end
   end

   assign irq = irq_reg;

   always_comb begin
      rd_mux = '0;
      if (avmm_addr == 3'd0)
         rd_mux = {25'b0, stop_cnt_reg, irq_en_reg, tmo_flag_reg, done_reg, busy};
      else if (avmm_addr == 3'd1)
         rd_mux = 32'(timeout_reg);
      else
         for (int k = 0; k < NUM_STOPS; k++)
            if (avmm_addr == 3'(k + 2))
               rd_mux = 32'(stop_ts_reg[k]);
   end

   always_ff @(posedge avmm_clk or posedge avmm_reset) begin
      if (avmm_reset)
         avmm_readdata <= '0;
      else if (rd_en)
         avmm_readdata <= rd_mux;
   end

endmodule

// File: tb/tb_tof_interval_counter.sv
// Bench for tof_interval_counter: a 5-stop/32-bit instance and a 1-stop/8-bit instance share
// the pulse inputs; results are checked against an edge-list model of each measurement.
module tb_tof_interval_counter;
   localparam int WAVE_LEN = 1024;
   localparam int SETTLE   = 10;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cs0 = 1'b0, cs1 = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [2:0]  addr = 3'd0;
   logic [31:0] wdata = '0;
   logic        start_in = 1'b0, stop_in = 1'b0;
   logic [31:0] rdata0, rdata1;
   logic        irq0, irq1;
   int          total = 0, bad = 0;

   logic start_w [WAVE_LEN];
   logic stop_w  [WAVE_LEN];
   logic irq_log [WAVE_LEN];
   logic done_log[WAVE_LEN];

   typedef struct packed {
      logic [31:0]      cnt;
      logic             done;
      logic             tmo;
      logic             busy;
      logic [5:0][31:0] ts;
   } res_t;

   tof_interval_counter #(.NUM_STOPS(5), .CNT_W(32), .SYNC_STAGES(2)) u_dut0 (
      .avmm_clk(clk), .avmm_reset(rst), .avmm_cs(cs0), .avmm_addr(addr),
      .avmm_write(wr), .avmm_writedata(wdata), .avmm_read(rd), .avmm_readdata(rdata0),
      .start_in(start_in), .stop_in(stop_in), .irq(irq0));

   tof_interval_counter #(.NUM_STOPS(1), .CNT_W(8), .SYNC_STAGES(2)) u_dut1 (
      .avmm_clk(clk), .avmm_reset(rst), .avmm_cs(cs1), .avmm_addr(addr),
      .avmm_write(wr), .avmm_writedata(wdata), .avmm_read(rd), .avmm_readdata(rdata1),
      .start_in(start_in), .stop_in(stop_in), .irq(irq1));

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic bus_write(input int sel, input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      cs0 = (sel == 0); cs1 = (sel == 1); addr = a; wr = 1'b1; wdata = d;
      @(negedge clk);
      cs0 = 1'b0; cs1 = 1'b0; wr = 1'b0;
   endtask

   task automatic bus_read(input int sel, input logic [2:0] a, output logic [31:0] d);
      @(negedge clk);
      cs0 = (sel == 0); cs1 = (sel == 1); addr = a; rd = 1'b1;
      @(negedge clk);
      cs0 = 1'b0; cs1 = 1'b0; rd = 1'b0;
      d = (sel == 0) ? rdata0 : rdata1;
   endtask

   task automatic read_regs(input int sel, output logic [31:0] st, output logic [31:0] tm,
                            output logic [5:0][31:0] ts);
      logic [31:0] v;
      bus_read(sel, 3'd0, st);
      bus_read(sel, 3'd1, tm);
      for (int k = 0; k < 6; k++) begin
         bus_read(sel, 3'(k + 2), v);
         ts[k] = v;
      end
   endtask

   task automatic clear_waves();
      for (int i = 0; i < WAVE_LEN; i++) begin
         start_w[i] = 1'b0;
         stop_w[i]  = 1'b0;
      end
   endtask

   task automatic pulse(input bit st, input int at, input int w);
      for (int i = at; i < at + w && i < WAVE_LEN; i++)
         if (st) start_w[i] = 1'b1;
         else    stop_w[i]  = 1'b1;
   endtask

   // Plays the waveforms one cycle at a time while polling dut0 status every cycle
   task automatic run_wave(input int len);
      for (int c = 0; c <= len; c++) begin
         @(negedge clk);
         if (c > 0) begin
            irq_log[c-1]  = irq0;
            done_log[c-1] = rdata0[1];
         end
         if (c < len) begin
            start_in = start_w[c]; stop_in = stop_w[c];
            cs0 = 1'b1; rd = 1'b1; addr = 3'd0;
         end else begin
            start_in = 1'b0; stop_in = 1'b0;
            cs0 = 1'b0; rd = 1'b0;
         end
      end
      repeat (SETTLE) @(negedge clk);
   endtask

   task automatic arm_both(input int t0, input int t1, input logic en);
      bus_write(0, 3'd0, {29'b0, en, 2'b10});
      bus_write(1, 3'd0, {29'b0, en, 2'b10});
      bus_write(0, 3'd1, 32'(t0));
      bus_write(1, 3'd1, 32'(t1));
      bus_write(0, 3'd0, {29'b0, en, 2'b01});
      bus_write(1, 3'd0, {29'b0, en, 2'b01});
   endtask

   function automatic bit is_edge(input bit st, input int c);
      bit cur, prev;
      cur  = st ? start_w[c] : stop_w[c];
      prev = 1'b0;
      if (c > 0) prev = st ? start_w[c-1] : stop_w[c-1];
      return cur & ~prev;
   endfunction

   // Reference: interval = stop edge cycle - first start edge cycle, clipped to counter range
   function automatic res_t model(input int nstops, input int cntw, input int tmo, input int len);
      res_t   r;
      int     s, k, n;
      longint maxv;
      r = '0; s = -1; k = 0;
      for (int c = 0; c < len; c++)
         if (is_edge(1'b1, c)) begin s = c; break; end
      if (s < 0) begin r.busy = 1'b1; return r; end
      maxv = (longint'(1) << cntw) - 1;
      for (int c = s + 1; c < len; c++) begin
         if (is_edge(1'b0, c)) begin
            n = c - s;
            if (tmo != 0 && n > tmo) break;
            r.ts[k] = (longint'(n) > maxv) ? maxv[31:0] : 32'(n);
            k++;
            if (k == nstops) break;
         end
      end
      r.cnt = 32'(k);
      if (k == nstops) r.done = 1'b1;
      else if (tmo != 0) begin r.done = 1'b1; r.tmo = 1'b1; end
      else r.busy = 1'b1;
      return r;
   endfunction

   function automatic logic [31:0] status_of(input res_t r, input logic en);
      return {25'b0, r.cnt[2:0], en, r.tmo, r.done, r.busy};
   endfunction

   task automatic test_reset();
      logic [31:0] st, tm;
      logic [5:0][31:0] ts;
      read_regs(0, st, tm, ts);
      total++; if (st !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=%h", st, 32'h0); end
      total++; if (tm !== 32'h0) begin bad++; $display("FAIL reset_timeout got=%h exp=%h", tm, 32'h0); end
      for (int k = 0; k < 6; k++) begin
         total++; if (ts[k] !== 32'h0) begin bad++; $display("FAIL reset_stop%0d got=%h exp=0", k, ts[k]); end
      end
      total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq0); end
      bus_write(0, 3'd7, 32'hFFFF_FFFF);
      bus_write(0, 3'd2, 32'h1234_5678);
      read_regs(0, st, tm, ts);
      total++; if (ts[5] !== 32'h0) begin bad++; $display("FAIL unused_addr got=%h exp=0", ts[5]); end
      total++; if (ts[0] !== 32'h0) begin bad++; $display("FAIL ro_stop0 got=%h exp=0", ts[0]); end
      total++; if (st !== 32'h0) begin bad++; $display("FAIL unused_wr_status got=%h exp=0", st); end
      $display("meas reset status=%h timeout=%h", st, tm);
   endtask

   task automatic test_plan(input int tmo, input string name);
      logic [31:0] st, tm;
      logic [5:0][31:0] ts, exp_ts;
      logic [31:0] exp_st;
      clear_waves();
      pulse(1, 10, 10);
      pulse(0, 20, 10); pulse(0, 50, 10); pulse(0, 100, 10); pulse(0, 200, 10); pulse(0, 500, 10);
      arm_both(tmo, tmo, 1'b0);
      run_wave(530);
      exp_ts = '0;
      exp_ts[0] = 32'd10; exp_ts[1] = 32'd40; exp_ts[2] = 32'd90;
      if (tmo == 0) begin
         exp_ts[3] = 32'd190; exp_ts[4] = 32'd490; exp_st = 32'h52;
      end else begin
         exp_st = 32'h36;
      end
      read_regs(0, st, tm, ts);
      total++; if (st !== exp_st) begin bad++; $display("FAIL %s_status0 got=%h exp=%h", name, st, exp_st); end
      for (int k = 0; k < 6; k++) begin
         total++; if (ts[k] !== exp_ts[k]) begin bad++; $display("FAIL %s_stop%0d got=%0d exp=%0d", name, k, ts[k], exp_ts[k]); end
      end
      total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL %s_irq0 got=%b exp=0", name, irq0); end
      $display("meas %s dut0 status=%h", name, st);
      read_regs(1, st, tm, ts);
      total++; if (st !== 32'h12) begin bad++; $display("FAIL %s_status1 got=%h exp=%h", name, st, 32'h12); end
      total++; if (ts[0] !== 32'd10) begin bad++; $display("FAIL %s_d1stop0 got=%0d exp=10", name, ts[0]); end
      total++; if (ts[1] !== 32'd0) begin bad++; $display("FAIL %s_d1unused got=%0d exp=0", name, ts[1]); end
      $display("meas %s dut1 status=%h", name, st);
   endtask

   task automatic test_stop_on_timeout();
      logic [31:0] st, tm;
      logic [5:0][31:0] ts;
      clear_waves();
      pulse(1, 10, 10);
      pulse(0, 110, 10);
      arm_both(100, 100, 1'b0);
      run_wave(140);
      read_regs(0, st, tm, ts);
      total++; if (st !== 32'h16) begin bad++; $display("FAIL edge_tmo_status0 got=%h exp=%h", st, 32'h16); end
      total++; if (ts[0] !== 32'd100) begin bad++; $display("FAIL edge_tmo_stop0 got=%0d exp=100", ts[0]); end
      read_regs(1, st, tm, ts);
      total++; if (st !== 32'h12) begin bad++; $display("FAIL edge_tmo_status1 got=%h exp=%h", st, 32'h12); end
      total++; if (ts[0] !== 32'd100) begin bad++; $display("FAIL edge_tmo_d1stop0 got=%0d exp=100", ts[0]); end
      $display("meas stop_on_timeout dut1 status=%h", st);
   endtask

   task automatic test_ignored_pulses();
      logic [31:0] st, tm;
      logic [5:0][31:0] ts;
      res_t e0, e1;
      clear_waves();
      pulse(0, 2, 3); pulse(0, 8, 3);
      pulse(1, 20, 4); pulse(1, 45, 4);
      pulse(0, 30, 3); pulse(0, 60, 3); pulse(0, 90, 3);
      arm_both(0, 0, 1'b0);
      run_wave(120);
      e0 = model(5, 32, 0, 120);
      e1 = model(1, 8, 0, 120);
      read_regs(0, st, tm, ts);
      total++; if (st !== status_of(e0, 1'b0)) begin bad++; $display("FAIL ignore_status0 got=%h exp=%h", st, status_of(e0, 1'b0)); end
      total++; if (ts[0] !== 32'd10) begin bad++; $display("FAIL ignore_stop0 got=%0d exp=10", ts[0]); end
      for (int k = 0; k < 6; k++) begin
         total++; if (ts[k] !== e0.ts[k]) begin bad++; $display("FAIL ignore_stop%0d got=%0d exp=%0d", k, ts[k], e0.ts[k]); end
      end
      read_regs(1, st, tm, ts);
      total++; if (st !== status_of(e1, 1'b0)) begin bad++; $display("FAIL ignore_status1 got=%h exp=%h", st, status_of(e1, 1'b0)); end
      total++; if (ts[0] !== e1.ts[0]) begin bad++; $display("FAIL ignore_d1stop0 got=%0d exp=%0d", ts[0], e1.ts[0]); end
      $display("meas ignored_pulses dut1 status=%h", st);
   endtask

   task automatic test_irq_clear();
      logic [31:0] st, tm;
      logic [5:0][31:0] ts;
      bit saw;
      clear_waves();
      pulse(1, 5, 5);
      pulse(0, 25, 5);
      arm_both(60, 60, 1'b1);
      run_wave(100);
      saw = 1'b0;
      for (int c = 0; c < 100; c++) begin
         saw |= irq_log[c];
         total++;
         if (irq_log[c] !== done_log[c]) begin
            bad++; $display("FAIL irq_follows_done c=%0d got=%b exp=%b", c, irq_log[c], done_log[c]);
         end
      end
      total++; if (saw !== 1'b1) begin bad++; $display("FAIL irq_seen got=%b exp=1", saw); end
      total++; if (irq0 !== 1'b1) begin bad++; $display("FAIL irq0_high got=%b exp=1", irq0); end
      total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL irq1_high got=%b exp=1", irq1); end
      bus_read(0, 3'd0, st);
      total++; if (st !== 32'h1E) begin bad++; $display("FAIL irq_status0 got=%h exp=%h", st, 32'h1E); end
      bus_read(1, 3'd0, st);
      total++; if (st !== 32'h1A) begin bad++; $display("FAIL irq_status1 got=%h exp=%h", st, 32'h1A); end
      bus_write(0, 3'd0, 32'h6);
      read_regs(0, st, tm, ts);
      total++; if (st !== 32'h08) begin bad++; $display("FAIL clear_status got=%h exp=%h", st, 32'h08); end
      total++; if (tm !== 32'd60) begin bad++; $display("FAIL clear_timeout got=%0d exp=60", tm); end
      for (int k = 0; k < 6; k++) begin
         total++; if (ts[k] !== 32'h0) begin bad++; $display("FAIL clear_stop%0d got=%0d exp=0", k, ts[k]); end
      end
      total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL clear_irq got=%b exp=0", irq0); end
      bus_write(0, 3'd0, 32'h5);
      bus_read(0, 3'd0, st);
      total++; if (st !== 32'h09) begin bad++; $display("FAIL arm_status got=%h exp=%h", st, 32'h09); end
      bus_write(0, 3'd0, 32'h7);
      bus_read(0, 3'd0, st);
      total++; if (st !== 32'h08) begin bad++; $display("FAIL arm_clear_status got=%h exp=%h", st, 32'h08); end
      $display("meas irq_clear dut0 status=%h", st);
   endtask

   task automatic test_saturation();
      logic [31:0] st, tm;
      logic [5:0][31:0] ts;
      res_t e0, e1;
      clear_waves();
      pulse(1, 5, 5);
      pulse(0, 305, 5);
      arm_both(0, 0, 1'b0);
      run_wave(330);
      e0 = model(5, 32, 0, 330);
      e1 = model(1, 8, 0, 330);
      read_regs(1, st, tm, ts);
      total++; if (ts[0] !== 32'd255) begin bad++; $display("FAIL sat_stop0 got=%0d exp=255", ts[0]); end
      total++; if (st !== status_of(e1, 1'b0)) begin bad++; $display("FAIL sat_status1 got=%h exp=%h", st, status_of(e1, 1'b0)); end
      read_regs(0, st, tm, ts);
      total++; if (ts[0] !== e0.ts[0]) begin bad++; $display("FAIL sat_d0stop0 got=%0d exp=%0d", ts[0], e0.ts[0]); end
      total++; if (st !== status_of(e0, 1'b0)) begin bad++; $display("FAIL sat_status0 got=%h exp=%h", st, status_of(e0, 1'b0)); end
      $display("meas saturation dut0 status=%h", st);
   endtask

   task automatic test_random(input int iters);
      logic [31:0] st, tm;
      logic [5:0][31:0] ts;
      res_t e0, e1;
      int s, c, w, t0, t1;
      for (int it = 0; it < iters; it++) begin
         clear_waves();
         s = $urandom_range(80, 5);
         pulse(1, s, $urandom_range(6, 1));
         if ($urandom_range(1, 0) == 1) pulse(1, s + $urandom_range(100, 20), $urandom_range(6, 1));
         c = $urandom_range(30, 0);
         while (c < 380) begin
            w = $urandom_range(6, 1);
            pulse(0, c, w);
            c += w + $urandom_range(60, 1);
         end
         t0 = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(300, 1);
         t1 = t0 & 255;
         arm_both(t0, t1, 1'b0);
         run_wave(400);
         e0 = model(5, 32, t0, 400);
         e1 = model(1, 8, t1, 400);
         read_regs(0, st, tm, ts);
         total++; if (st !== status_of(e0, 1'b0)) begin bad++; $display("FAIL rnd%0d_status0 got=%h exp=%h", it, st, status_of(e0, 1'b0)); end
         total++; if (tm !== 32'(t0)) begin bad++; $display("FAIL rnd%0d_timeout0 got=%0d exp=%0d", it, tm, t0); end
         for (int k = 0; k < 6; k++) begin
            total++; if (ts[k] !== e0.ts[k]) begin bad++; $display("FAIL rnd%0d_stop%0d got=%0d exp=%0d", it, k, ts[k], e0.ts[k]); end
         end
         $display("meas random%0d t=%0d dut0 status=%h", it, t0, st);
         read_regs(1, st, tm, ts);
         total++; if (st !== status_of(e1, 1'b0)) begin bad++; $display("FAIL rnd%0d_status1 got=%h exp=%h", it, st, status_of(e1, 1'b0)); end
         for (int k = 0; k < 6; k++) begin
            total++; if (ts[k] !== e1.ts[k]) begin bad++; $display("FAIL rnd%0d_d1stop%0d got=%0d exp=%0d", it, k, ts[k], e1.ts[k]); end
         end
         $display("meas random%0d t=%0d dut1 status=%h", it, t1, st);
      end
   endtask

   task automatic test_async_reset();
      logic [31:0] st, tm, v;
      logic [5:0][31:0] ts;
      clear_waves();
      pulse(1, 3, 4);
      pulse(0, 13, 4);
      arm_both(1000, 0, 1'b1);
      run_wave(25);
      total++; if (irq1 !== 1'b1) begin bad++; $display("FAIL pre_reset_irq1 got=%b exp=1", irq1); end
      bus_read(0, 3'd1, v);
      total++; if (v !== 32'd1000) begin bad++; $display("FAIL pre_reset_timeout got=%0d exp=1000", v); end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++; if (rdata0 !== 32'h0) begin bad++; $display("FAIL async_rdata0 got=%h exp=0", rdata0); end
      total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL async_rdata1 got=%h exp=0", rdata1); end
      total++; if (irq1 !== 1'b0) begin bad++; $display("FAIL async_irq1 got=%b exp=0", irq1); end
      total++; if (irq0 !== 1'b0) begin bad++; $display("FAIL async_irq0 got=%b exp=0", irq0); end
      @(negedge clk);
      rst = 1'b0;
      read_regs(0, st, tm, ts);
      total++; if (st !== 32'h0) begin bad++; $display("FAIL post_reset_status got=%h exp=0", st); end
      total++; if (tm !== 32'h0) begin bad++; $display("FAIL post_reset_timeout got=%h exp=0", tm); end
      for (int k = 0; k < 6; k++) begin
         total++; if (ts[k] !== 32'h0) begin bad++; $display("FAIL post_reset_stop%0d got=%0d exp=0", k, ts[k]); end
      end
      clear_waves();
      pulse(1, 2, 3);
      pulse(0, 10, 3);
      run_wave(30);
      read_regs(0, st, tm, ts);
      total++; if (st !== 32'h0) begin bad++; $display("FAIL unarmed_status got=%h exp=0", st); end
      total++; if (ts[0] !== 32'h0) begin bad++; $display("FAIL unarmed_stop0 got=%0d exp=0", ts[0]); end
      read_regs(1, st, tm, ts);
      total++; if (st !== 32'h0) begin bad++; $display("FAIL unarmed_status1 got=%h exp=0", st); end
      $display("meas async_reset dut0 status=%h", st);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_plan(0, "plan");
      test_plan(100, "timeout");
      test_stop_on_timeout();
      test_ignored_pulses();
      test_irq_clear();
      test_saturation();
      test_random(8);
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
